// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states and the constant-register map
// exposed by the read-only slave on the same bus.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_m_state_t;

  localparam int unsigned PI_HIGH_OFS = 0;
  localparam int unsigned PI_LOW_OFS  = 1;
  localparam int unsigned E_HIGH_OFS  = 2;
  localparam int unsigned E_LOW_OFS   = 3;

endpackage

// File: rtl/apb_const_reader.sv
// APB read requester: expands (addr, len) commands into single-word APB reads
// and hands each word to a valid/ready response stream.
module apb_const_reader
  import apb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int ADDR_STEP = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_m_state_t     state;
  logic [LEN_W-1:0] remaining;
  logic [TO_W-1:0]  to_cnt;
  logic             timeout_hit;

  assign pwrite      = 1'b0;
  assign pwdata      = '0;
  assign cmd_ready   = ~busy;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT));

  // paddr doubles as the running beat address between beats
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            remaining <= cmd_len;
            psel      <= 1'b1;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // a completing pready takes priority over a simultaneous timeout
          if (pready) begin
            rsp_data  <= prdata;
            rsp_err   <= pslverr;
            rsp_last  <= (remaining == '0) | pslverr;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              paddr     <= paddr + ADDR_W'(ADDR_STEP);
              remaining <= remaining - LEN_W'(1);
              psel      <= 1'b1;
              state     <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_const_reader.sv
// Directed bench for apb_const_reader with a behavioural constant-register
// APB slave (one wait state, pslverr above offset 3) and a response scoreboard.
module tb_apb_const_reader;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_last;
  logic              busy;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  apb_const_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_STEP(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // Behavioural slave: pready on the second ACCESS cycle unless stalled
  logic              stall;
  logic              acc_seen;
  logic [DATA_W-1:0] regs [4];

  initial begin
    regs[apb_pkg::PI_HIGH_OFS] = 32'hC90FDAA2;
    regs[apb_pkg::PI_LOW_OFS]  = 32'h2168C234;
    regs[apb_pkg::E_HIGH_OFS]  = 32'hADF85458;
    regs[apb_pkg::E_LOW_OFS]   = 32'hA2BB4A9A;
  end

  always @(posedge pclk) acc_seen <= psel & penable & ~pready;

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (psel && penable && acc_seen && !stall) begin
      pready = 1'b1;
      if (paddr > 32'd3) pslverr = 1'b1;
      else               prdata  = regs[paddr[1:0]];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard entries are {last, err, data}
  logic [33:0]       sb [$];
  logic [ADDR_W-1:0] addr_log [$];

  always @(negedge pclk) begin
    if (!preset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else chk("rsp_beat", {30'd0, rsp_last, rsp_err, rsp_data}, {30'd0, sb.pop_front()});
    end
    if (!preset && psel && !penable) addr_log.push_back(paddr);
  end

  task automatic drive_step();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    drive_step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge pclk);
    while ((busy || rsp_valid) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n = 0;
    @(negedge pclk);
    while (!rsp_valid && n < 100) begin
      @(negedge pclk);
      n++;
    end
    chk(tag, {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    int acc_cycles;
    int n;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rsp_ready = 1'b1;
    stall     = 1'b0;
    drive_step();
    drive_step();
    preset = 1'b0;

    @(negedge pclk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_psel",      {63'd0, psel},      64'd0);
    chk("rst_penable",   {63'd0, penable},   64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_paddr",     64'(paddr),         64'd0);
    chk("rst_rsp_data",  64'(rsp_data),      64'd0);
    chk("rst_pwrite",    {63'd0, pwrite},    64'd0);

    // Single read with latency checks
    sb.push_back({1'b1, 1'b0, 32'hC90FDAA2});
    drive_step();
    send_cmd(32'd0, 4'd0);
    @(negedge pclk);
    chk("n1_psel",    {62'd0, psel, penable}, 64'b10);
    @(negedge pclk);
    chk("n2_penable", {62'd0, psel, penable}, 64'b11);
    @(negedge pclk);
    chk("n3_no_rsp",  {63'd0, rsp_valid},     64'd0);
    @(negedge pclk);
    chk("n4_rsp",     {63'd0, rsp_valid},     64'd1);
    wait_idle("single_idle");

    // Burst of four
    addr_log.delete();
    sb.push_back({1'b0, 1'b0, 32'hC90FDAA2});
    sb.push_back({1'b0, 1'b0, 32'h2168C234});
    sb.push_back({1'b0, 1'b0, 32'hADF85458});
    sb.push_back({1'b1, 1'b0, 32'hA2BB4A9A});
    drive_step();
    send_cmd(32'd0, 4'd3);
    wait_idle("burst_idle");
    chk("burst_nbeats", 64'(addr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      chk("burst_paddr", 64'(addr_log[i]), 64'(i));

    // Backpressure on beat 2
    sb.push_back({1'b0, 1'b0, 32'hC90FDAA2});
    sb.push_back({1'b0, 1'b0, 32'h2168C234});
    sb.push_back({1'b0, 1'b0, 32'hADF85458});
    sb.push_back({1'b1, 1'b0, 32'hA2BB4A9A});
    drive_step();
    rsp_ready = 1'b0;
    send_cmd(32'd0, 4'd3);
    wait_rsp_valid("bp_beat1_valid");
    drive_step();
    rsp_ready = 1'b1;
    drive_step();
    rsp_ready = 1'b0;
    wait_rsp_valid("bp_beat2_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge pclk);
      chk("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_hold_data",  64'(rsp_data),      64'h2168C234);
      chk("bp_hold_psel",  {63'd0, psel},      64'd0);
    end
    drive_step();
    rsp_ready = 1'b1;
    wait_idle("bp_idle");

    // Slave error ends the burst at addr 4
    addr_log.delete();
    sb.push_back({1'b0, 1'b0, 32'hADF85458});
    sb.push_back({1'b0, 1'b0, 32'hA2BB4A9A});
    sb.push_back({1'b1, 1'b1, 32'h00000000});
    drive_step();
    send_cmd(32'd2, 4'd3);
    wait_idle("err_idle");
    chk("err_nbeats", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() > 0) chk("err_last_addr", 64'(addr_log[addr_log.size()-1]), 64'd4);
    chk("err_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Timeout against a stalled slave
    stall = 1'b1;
    sb.push_back({1'b1, 1'b1, 32'h00000000});
    drive_step();
    send_cmd(32'd0, 4'd0);
    acc_cycles = 0;
    n = 0;
    @(negedge pclk);
    while (!rsp_valid && n < 100) begin
      if (penable) acc_cycles++;
      @(negedge pclk);
      n++;
    end
    chk("to_valid",       {63'd0, rsp_valid}, 64'd1);
    chk("to_access_cycles", 64'(acc_cycles),  64'(TIMEOUT + 1));
    chk("to_psel_resp",   {63'd0, psel},      64'd0);
    wait_idle("to_idle");
    stall = 1'b0;

    // Reset during the ACCESS phase of beat 2
    sb.push_back({1'b0, 1'b0, 32'hC90FDAA2});
    drive_step();
    send_cmd(32'd0, 4'd3);
    n = 0;
    @(negedge pclk);
    while (!(penable && paddr == 32'd1) && n < 100) begin
      @(negedge pclk);
      n++;
    end
    chk("mid_access_beat2", {63'd0, penable}, 64'd1);
    drive_step();
    preset = 1'b1;
    drive_step();
    preset = 1'b0;
    @(negedge pclk);
    chk("mid_rst_psel",      {63'd0, psel},      64'd0);
    chk("mid_rst_penable",   {63'd0, penable},   64'd0);
    chk("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    sb.push_back({1'b1, 1'b0, 32'hA2BB4A9A});
    drive_step();
    send_cmd(32'd3, 4'd0);
    wait_idle("post_rst_idle");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/apb_const_reader.md
# apb_const_reader

APB requester that turns a simple command (base address, word count) into a burst of single-word APB read transfers and returns each word on a valid/ready response stream. It sits on the initiator side of the APB bus shared with `apb_slave`, the read-only register responder. It fetches the slave's constant words (pi/e high/low) for downstream consumers.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `LEN_W`, 4, command length width; burst = `cmd_len`+1 words (1..16)
- `ADDR_STEP`, 1, paddr increment per beat (slave registers are word-indexed)
- `TIMEOUT`, 16, max ACCESS cycles without `pready` before abort; 0 disables

Ports:
- `pclk` in 1: clock, all logic on rising edge
- `preset` in 1: reset, synchronous, active-high
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: command accepted when both high at an edge
- `cmd_addr` in ADDR_W: first word address
- `cmd_len` in LEN_W: words minus one
- `rsp_valid` out 1: response word available
- `rsp_ready` in 1: consumer accepts response
- `rsp_data` out DATA_W: read word (0 on error)
- `rsp_err` out 1: `pslverr` seen or timeout
- `rsp_last` out 1: final beat of the command
- `busy` out 1: command in progress
- `paddr` out ADDR_W, `psel` out 1, `penable` out 1: APB request
- `pwrite` out 1, `pwdata` out DATA_W: tied 0
- `pready` in 1, `pslverr` in 1, `prdata` in DATA_W: APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB and rsp outputs are registered.
- IDLE: `cmd_ready`=1, `busy`=0. On handshake, latch addr/len, go to SETUP.
- SETUP (1 cycle): `psel`=1, `penable`=0, `paddr`=current addr. Next state is ACCESS.
- ACCESS: `psel`=1, `penable`=1. Timeout counter clears on entry and increments each cycle with `pready`=0.
  - On `pready`=1: capture `prdata`→`rsp_data` and `pslverr`→`rsp_err`. Set `rsp_last` = (remaining==0) | `pslverr`. Drop `psel`/`penable`, go to RESP.
  - On counter == TIMEOUT (TIMEOUT≠0): `rsp_data`=0, `rsp_err`=1, `rsp_last`=1. Drop `psel`/`penable`, go to RESP.
- RESP: `rsp_valid`=1. `rsp_data`, `rsp_err` and `rsp_last` stay stable until `rsp_ready`. On accept:
  - If `rsp_last`: go to IDLE.
  - Else: addr += ADDR_STEP (mod 2^ADDR_W), remaining -= 1, go to SETUP.
- `pslverr` and `prdata` are sampled only in the cycle with `psel`&`penable`&`pready`.
- An error (slave or timeout) ends the burst; remaining beats are dropped.
- Commands are ignored while `busy`. `cmd_ready` is 0 outside IDLE.

## Timing
- Reset values: `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_valid`, `rsp_data`, `rsp_err`, `rsp_last`, `busy` are all 0. State is IDLE, so `cmd_ready`=1 after the reset edge.
- Reset mid-operation: the in-flight transfer and burst are discarded with no response. `psel`/`penable` are 0 on the next cycle.
- Command accepted at edge N:
  - `psel`=1 in cycle N+1.
  - `penable`=1 in cycle N+2.
  - If `pready` arrives in cycle N+2+w, `rsp_valid`=1 in cycle N+3+w.
- Against `apb_slave` (w=1), the first `rsp_valid` is in cycle N+4.
- Per-beat minimum is 1 SETUP + (1+w) ACCESS + 1 RESP cycles, with `rsp_ready` held high.
- No back-to-back ACCESS: every beat begins with a fresh SETUP cycle (`psel` stays high from RESP→SETUP? No: `psel`=0 during RESP).
- Timeout fires in ACCESS cycle TIMEOUT+1, i.e. after TIMEOUT cycles with `pready` low.
- Simultaneous `pready` and timeout in the same cycle: `pready` wins.

## Structure
- Shared package `apb_pkg` holds:
  - enum `apb_m_state_t` {IDLE, SETUP, ACCESS, RESP}
  - constant register offsets `PI_HIGH_OFS`=0, `PI_LOW_OFS`=1, `E_HIGH_OFS`=2, `E_LOW_OFS`=3
- Single module; no sub-module. The timeout counter is `$clog2(TIMEOUT+1)` bits, inline.

## Test plan
- Single read, addr 0, len 0, against `apb_slave`. Expect `rsp_data`=0xC90FDAA2, `rsp_err`=0, `rsp_last`=1. `psel` rises at N+1, `penable` at N+2, `rsp_valid` at N+4.
- Burst, addr 0, len 3. Expect `paddr` sequence 0,1,2,3 and data 0xC90FDAA2, 0x2168C234, 0xADF85458, 0xA2BB4A9A. `rsp_last` is set only on beat 4.
- Backpressure: hold `rsp_ready`=0 for 5 cycles on beat 2. `rsp_valid` and `rsp_data`=0x2168C234 stay stable, and `psel` stays 0 until the beat is accepted.
- Slave error: addr 2, len 3. Expect beats at 2 and 3 to return OK. The beat at addr 4 returns `rsp_err`=1 with `rsp_last`=1. No transfer to addr 5 occurs. Then `busy`=0.
- Timeout: model slave holds `pready`=0, TIMEOUT=16. After 16 stalled ACCESS cycles expect `rsp_err`=1, `rsp_data`=0, `rsp_last`=1, and `psel`=0 in RESP.
- Reset mid-burst: assert `preset` during ACCESS of beat 2. Next cycle: `psel`=`penable`=`rsp_valid`=0 and `cmd_ready`=1. A fresh addr 3 read returns 0xA2BB4A9A.
